// File: rtl/ovl_win_stim_gen.sv
// rtl/ovl_win_stim_gen.sv - window stimulus generator driving start/end events and test_expr
module ovl_win_stim_gen #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_windows,
    input  logic [CNT_W-1:0] win_len,
    input  logic [CNT_W-1:0] gap_len,
    input  logic [WIDTH-1:0] value_a,
    input  logic [WIDTH-1:0] value_b,
    input  logic             mutate,
    input  logic [CNT_W-1:0] mutate_at,
    output logic             start_event,
    output logic             end_event,
    output logic [WIDTH-1:0] test_expr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] win_count
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_HOLD, S_END, S_GAP} state_e;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] win_count_q, win_count_d;
    logic [CNT_W-1:0] num_q, win_len_q, gap_len_q, mut_at_q;
    logic [WIDTH-1:0] val_a_q, val_b_q;
    logic             mutate_q;

    logic             start_q, start_d, end_q, end_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] expr_q, expr_d;

    logic             accept;
    logic [CNT_W-1:0] num_e, win_len_e, gap_len_e, mut_at_e;
    logic [WIDTH-1:0] val_a_e, val_b_e, win_val;
    logic             mutate_e, mut_active;

    // On the accepting cycle the live inputs are used so START can be decoded
    // in the same cycle the configuration is captured.
    assign accept    = (state_q == S_IDLE) && go;
    assign num_e     = accept ? num_windows : num_q;
    assign win_len_e = accept ? win_len     : win_len_q;
    assign gap_len_e = accept ? gap_len     : gap_len_q;
    assign mut_at_e  = accept ? mutate_at   : mut_at_q;
    assign val_a_e   = accept ? value_a     : val_a_q;
    assign val_b_e   = accept ? value_b     : val_b_q;
    assign mutate_e  = accept ? mutate      : mutate_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_count_d = win_count_q;
        done_d      = 1'b0;
        expr_d      = '0;
        win_val     = '0;
        mut_active  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    if (num_windows != '0) begin
                        state_d     = S_START;
                        win_count_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = (win_len_e == '0) ? S_END : S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q == win_len_e - ONE) state_d = S_END;
                else                          cnt_d   = cnt_q + ONE;
            end
            S_END: begin
                win_count_d = win_count_q + ONE;
                cnt_d       = '0;
                if (win_count_d == num_e) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (gap_len_e == '0) begin
                    state_d = S_START;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == gap_len_e - ONE) state_d = S_START;
                else                          cnt_d   = cnt_q + ONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            win_count_d = win_count_q;
            done_d      = 1'b0;
        end

        // Outputs are decoded from the next state so they register alongside it.
        win_val    = win_count_d[0] ? val_b_e : val_a_e;
        mut_active = mutate_e && (mut_at_e < win_len_e);
        case (state_d)
            S_START: expr_d = win_val;
            S_HOLD:  expr_d = (mut_active && (cnt_d >= mut_at_e)) ? ~win_val : win_val;
            S_END:   expr_d = mut_active ? ~win_val : win_val;
            default: expr_d = '0;
        endcase
    end

    assign start_d = (state_d == S_START);
    assign end_d   = (state_d == S_END);
    assign busy_d  = (state_d != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            win_count_q <= '0;
            num_q       <= '0;
            win_len_q   <= '0;
            gap_len_q   <= '0;
            mut_at_q    <= '0;
            val_a_q     <= '0;
            val_b_q     <= '0;
            mutate_q    <= 1'b0;
            start_q     <= 1'b0;
            end_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            expr_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_count_q <= win_count_d;
            if (accept) begin
                num_q     <= num_windows;
                win_len_q <= win_len;
                gap_len_q <= gap_len;
                mut_at_q  <= mutate_at;
                val_a_q   <= value_a;
                val_b_q   <= value_b;
                mutate_q  <= mutate;
            end
            start_q <= start_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            expr_q  <= expr_d;
        end
    end

    assign start_event = start_q;
    assign end_event   = end_q;
    assign test_expr   = expr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign win_count   = win_count_q;

endmodule

// File: doc/ovl_win_stim_gen.md
OVL_WIN_STIM_GEN -- requirements
Module: ovl_win_stim_gen

Interface
REQ-001 Parameter WIDTH, default 4, width of test_expr and window values.
REQ-002 Parameter CNT_W, default 8, width of all length/count fields.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 go  input  1  starts a sequence when sampled high in IDLE.
REQ-006 abort  input  1  synchronous abort of a running sequence.
REQ-007 num_windows  input  CNT_W  number of windows to generate.
REQ-008 win_len  input  CNT_W  HOLD cycles between start_event and end_event.
REQ-009 gap_len  input  CNT_W  idle cycles between windows.
REQ-010 value_a, value_b  input  WIDTH each  test_expr values for even- and odd-numbered windows.
REQ-011 mutate  input  1  inject a test_expr change inside each window (fail stimulus).
REQ-012 mutate_at  input  CNT_W  HOLD cycle index (0-based) at which the mutation starts.
REQ-013 start_event  output  1  one-cycle window-open pulse.
REQ-014 end_event  output  1  one-cycle window-close pulse.
REQ-015 test_expr  output  WIDTH  expression driven to the window checker.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse on normal sequence completion.
REQ-018 win_count  output  CNT_W  windows completed in the current sequence.

Function
REQ-019 FSM states SHALL be IDLE, START, HOLD, END, GAP; exactly one active per cycle.
REQ-020 num_windows, win_len, gap_len, value_a, value_b, mutate, mutate_at SHALL be captured on the accepted go cycle; later input changes have no effect until the next sequence.
REQ-021 IDLE, go=1, captured num_windows!=0: next state START, win_count cleared to 0.
REQ-022 IDLE, go=1, num_windows==0: done pulses in the next cycle, state stays IDLE.
REQ-023 go while busy SHALL be ignored.
REQ-024 START lasts exactly 1 cycle: start_event=1, test_expr=window value (value_a if win_count even, else value_b).
REQ-025 HOLD lasts exactly win_len cycles; win_len==0 makes END directly follow START.
REQ-026 When mutate=1 and mutate_at<win_len, test_expr SHALL equal bitwise-inverted window value from HOLD cycle mutate_at through the END cycle inclusive; otherwise test_expr stays at window value through END.
REQ-027 END lasts 1 cycle: end_event=1; win_count increments by 1 at the end of that cycle.
REQ-028 After END: if incremented win_count==num_windows, go to IDLE with done=1 in the first IDLE cycle; else GAP.
REQ-029 GAP lasts gap_len cycles with test_expr=0; gap_len==0 makes START directly follow END.
REQ-030 In IDLE, test_expr, start_event, end_event SHALL be 0.
REQ-031 start_event and end_event SHALL never be high in the same cycle.
REQ-032 abort=1 in any non-IDLE state: next state IDLE, all pulses and test_expr 0, win_count held, no done pulse; abort has priority over go and all transitions.
REQ-033 win_count SHALL not wrap; maximum sequence length is 2^CNT_W-1 windows.
REQ-034 All outputs SHALL be registered (no combinational input-to-output paths).

Reset
REQ-035 rst_n low SHALL immediately force IDLE and drive start_event, end_event, test_expr, busy, done, win_count to 0.
REQ-036 rst_n deassertion mid-sequence SHALL resume in IDLE; no done pulse; first possible START is the cycle after a go accepted post-reset.

Verification
REQ-037 go at cycle 0, num_windows=1, win_len=3, gap_len=2, value_a=4'b0011, mutate=0 -> start_event cycle 1, test_expr=0011 cycles 1-5, end_event cycle 5, done cycle 6, win_count=1.
REQ-038 num_windows=2, win_len=2, gap_len=2, value_a=4'b0001, value_b=4'b1001 -> windows open cycles 1 and 7, test_expr=0000 cycles 5-6, second window drives 1001, done cycle 11.
REQ-039 num_windows=1, win_len=4, value_a=4'b0011, mutate=1, mutate_at=1 -> test_expr 0011 cycles 1-2, 1100 cycles 3-6, end_event cycle 6; same with mutate_at=4 -> no mutation.
REQ-040 win_len=0, gap_len=0, num_windows=3 -> start/end alternate every cycle, never coincident, done after third end_event.
REQ-041 abort asserted in HOLD of window 2 of 3 -> IDLE next cycle, outputs 0, no done, win_count=1; go during busy ignored.
REQ-042 rst_n pulsed low mid-HOLD -> all outputs 0 asynchronously, no done; num_windows=0 with go -> done next cycle, busy stays 0.
